// File: rtl/ysyx_22041752_dcache_req_stage_pkg.sv
// Shared constants for the D-cache request stage.
//   - Default geometry of the D-cache read port (ways, index/offset widths).
//   - Encoding of the request-stage state register.
package ysyx_22041752_dcache_req_stage_pkg;

  localparam int unsigned DCACHE_WAYS      = 4;
  localparam int unsigned DCACHE_ADDR_WD   = 64;
  localparam int unsigned DCACHE_DATA_WD   = 64;
  localparam int unsigned DCACHE_WEN_WD    = DCACHE_DATA_WD / 8;
  localparam int unsigned DCACHE_OFFSET_WD = 4;
  localparam int unsigned DCACHE_INDEX_WD  = 6;

  // {addr, wdata, wen, way_read_mask}
  localparam int unsigned DRS_TO_DCS_BUS_WD =
      DCACHE_ADDR_WD + DCACHE_DATA_WD + DCACHE_WEN_WD + DCACHE_WAYS;

  // EMPTY: nothing held.
  // FRESH: request held and SRAM output belongs to its index.
  // STALE: request held, a re-read is in flight; data usable next cycle.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FRESH = 2'd1;
  localparam logic [1:0] ST_STALE = 2'd2;

endpackage

// File: rtl/ysyx_22041752_dcache_req_stage.sv
// D-cache request stage.
// Accepts LSU requests over valid/ready, issues tag/data SRAM reads on all ways and holds the
// request for the compare stage. While the compare stage stalls the read is replayed every cycle
// so the SRAM output always belongs to the held index. A same-index SRAM write (refill or store)
// marks the held data stale and forces one re-read before it is presented.
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   req_valid/req_ready          LSU handshake; req_addr/req_wdata/req_wen carry the request
//   flush                        drop the held request
//   wr_en/wr_index               SRAM write in progress and its set index
//   cs_valid/cs_ready/cs_bus     compare-stage handshake and held request {addr,wdata,wen,mask}
//   rd_cen/rd_addr               active-low per-way SRAM read enables and read index
module ysyx_22041752_dcache_req_stage
  import ysyx_22041752_dcache_req_stage_pkg::*;
#(
  parameter int unsigned WAYS      = DCACHE_WAYS,
  parameter int unsigned ADDR_WD   = DCACHE_ADDR_WD,
  parameter int unsigned DATA_WD   = DCACHE_DATA_WD,
  parameter int unsigned WEN_WD    = DCACHE_WEN_WD,
  parameter int unsigned OFFSET_WD = DCACHE_OFFSET_WD,
  parameter int unsigned INDEX_WD  = DCACHE_INDEX_WD,
  localparam int unsigned BUS_WD   = ADDR_WD + DATA_WD + WEN_WD + WAYS
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_WD-1:0]  req_addr,
  input  logic [DATA_WD-1:0]  req_wdata,
  input  logic [WEN_WD-1:0]   req_wen,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [INDEX_WD-1:0] wr_index,
  output logic                cs_valid,
  input  logic                cs_ready,
  output logic [BUS_WD-1:0]   cs_bus,
  output logic [WAYS-1:0]     rd_cen,
  output logic [INDEX_WD-1:0] rd_addr
);

  logic [1:0]          state_q, state_d;
  logic [ADDR_WD-1:0]  addr_q;
  logic [DATA_WD-1:0]  wdata_q;
  logic [WEN_WD-1:0]   wen_q;
  logic [WAYS-1:0]     mask_q;

  logic [INDEX_WD-1:0] req_index;
  logic [INDEX_WD-1:0] held_index;
  logic                held;
  logic                fire_out;
  logic                conflict;
  logic                accept;
  logic                replay;
  logic                req_wr_hit;
  logic                held_wr_hit;

  always_comb begin
    req_index   = req_addr[INDEX_WD+OFFSET_WD-1:OFFSET_WD];
    held_index  = addr_q[INDEX_WD+OFFSET_WD-1:OFFSET_WD];
    held        = (state_q != ST_EMPTY);
    req_wr_hit  = wr_en & (wr_index == req_index);
    held_wr_hit = wr_en & (wr_index == held_index);

    // Outputs are forced quiet while reset is held, even mid-request.
    cs_valid  = resetn & (state_q == ST_FRESH);
    fire_out  = cs_valid & cs_ready;
    conflict  = req_valid & req_wr_hit;
    req_ready = resetn & ~conflict & ~flush & (~held | fire_out);
    accept    = req_valid & req_ready;
    // Held and not leaving: keep re-reading so SRAM output tracks the held index.
    replay    = resetn & held & ~fire_out & ~flush;
  end

  // Read-port mux.
  always_comb begin
    rd_cen  = {WAYS{1'b1}};
    rd_addr = req_index;
    if (accept) begin
      rd_cen  = {WAYS{1'b0}};
      rd_addr = req_index;
    end else if (replay) begin
      rd_cen  = {WAYS{1'b0}};
      rd_addr = held_index;
    end
  end

  // Next state; flush outranks accept and completion.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = req_wr_hit ? ST_STALE : ST_FRESH;
    end else if (fire_out) begin
      state_d = ST_EMPTY;
    end else if (held) begin
      state_d = held_wr_hit ? ST_STALE : ST_FRESH;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wen_q   <= req_wen;
        mask_q  <= ~rd_cen;
      end
    end
  end

  assign cs_bus = {addr_q, wdata_q, wen_q, mask_q};

endmodule

// File: tb/tb_ysyx_22041752_dcache_req_stage.sv
module tb_ysyx_22041752_dcache_req_stage;

  localparam int BUS_WD = 64 + 64 + 8 + 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wen;
  logic              flush;
  logic              wr_en;
  logic [5:0]        wr_index;
  logic              cs_valid;
  logic              cs_ready;
  logic [BUS_WD-1:0] cs_bus;
  logic [3:0]        rd_cen;
  logic [5:0]        rd_addr;

  int checks   = 0;
  int failures = 0;

  ysyx_22041752_dcache_req_stage dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wen   (req_wen),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .cs_valid  (cs_valid),
    .cs_ready  (cs_ready),
    .cs_bus    (cs_bus),
    .rd_cen    (rd_cen),
    .rd_addr   (rd_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [BUS_WD-1:0] act,
                       input logic [BUS_WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rv, input logic [63:0] a, input logic [7:0] wn,
                       input logic fl, input logic we, input logic [5:0] wi, input logic csr);
    req_valid = rv;
    req_addr  = a;
    req_wdata = {32'hd00d_f00d, a[31:0]};
    req_wen   = wn;
    flush     = fl;
    wr_en     = we;
    wr_index  = wi;
    cs_ready  = csr;
  endtask

  typedef struct {
    logic        rv;
    logic [63:0] addr;
    logic [7:0]  wen;
    logic        fl;
    logic        we;
    logic [5:0]  wi;
    logic        csr;
    logic        rdy;
    logic        csv;
    logic [3:0]  cen;
    logic [5:0]  raddr;
    logic [63:0] haddr;
  } vec_t;

  vec_t tbl[12];

  // Reference model: a held request plus a "data not yet trustworthy" flag.
  logic        m_held, m_stale;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wen;
  logic [3:0]  m_mask;

  initial begin
    logic [63:0] a;
    logic [5:0]  ri, hi;
    logic        r, rv, fl, we, csr;
    logic [5:0]  wi;
    logic [7:0]  wn;
    logic        e_csv, e_rdy, fire, acc, rr;
    logic [3:0]  e_cen;
    logic [5:0]  e_raddr;

    resetn = 1'b0;
    drive(1'b0, 64'h0, 8'h0, 1'b0, 1'b0, 6'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Directed cycle table: stall replay, accept conflict, write hazard, flush.
    tbl[0]  = '{1, 64'h8000_0130, 8'h00, 0, 0, 6'h00, 0, 1, 0, 4'h0, 6'h13, 64'h0};
    tbl[1]  = '{0, 64'h8000_0130, 8'h00, 0, 0, 6'h00, 0, 0, 1, 4'h0, 6'h13, 64'h8000_0130};
    tbl[2]  = '{0, 64'h8000_0130, 8'h00, 0, 0, 6'h00, 0, 0, 1, 4'h0, 6'h13, 64'h8000_0130};
    tbl[3]  = '{0, 64'h8000_0130, 8'h00, 0, 0, 6'h00, 0, 0, 1, 4'h0, 6'h13, 64'h8000_0130};
    tbl[4]  = '{0, 64'h8000_0130, 8'h00, 0, 0, 6'h00, 1, 1, 1, 4'hf, 6'h13, 64'h8000_0130};
    tbl[5]  = '{1, 64'h8000_02a0, 8'h00, 0, 1, 6'h2a, 0, 0, 0, 4'hf, 6'h2a, 64'h8000_0130};
    tbl[6]  = '{1, 64'h8000_02a0, 8'h00, 0, 0, 6'h2a, 0, 1, 0, 4'h0, 6'h2a, 64'h8000_0130};
    tbl[7]  = '{1, 64'h8000_0050, 8'hff, 0, 0, 6'h00, 1, 1, 1, 4'h0, 6'h05, 64'h8000_02a0};
    tbl[8]  = '{0, 64'h8000_0050, 8'h00, 0, 1, 6'h05, 0, 0, 1, 4'h0, 6'h05, 64'h8000_0050};
    tbl[9]  = '{0, 64'h8000_0050, 8'h00, 0, 0, 6'h05, 0, 0, 0, 4'h0, 6'h05, 64'h8000_0050};
    tbl[10] = '{1, 64'h8000_0050, 8'hff, 1, 0, 6'h00, 0, 0, 1, 4'hf, 6'h05, 64'h8000_0050};
    tbl[11] = '{0, 64'h8000_0050, 8'h00, 0, 0, 6'h00, 0, 1, 0, 4'hf, 6'h05, 64'h8000_0050};

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].rv, tbl[i].addr, tbl[i].wen, tbl[i].fl, tbl[i].we, tbl[i].wi, tbl[i].csr);
      #1;
      check($sformatf("tbl%0d.req_ready", i), BUS_WD'(req_ready), BUS_WD'(tbl[i].rdy));
      check($sformatf("tbl%0d.cs_valid", i), BUS_WD'(cs_valid), BUS_WD'(tbl[i].csv));
      check($sformatf("tbl%0d.rd_cen", i), BUS_WD'(rd_cen), BUS_WD'(tbl[i].cen));
      check($sformatf("tbl%0d.rd_addr", i), BUS_WD'(rd_addr), BUS_WD'(tbl[i].raddr));
      check($sformatf("tbl%0d.bus_addr", i), BUS_WD'(cs_bus[BUS_WD-1 -: 64]),
            BUS_WD'(tbl[i].haddr));
      @(negedge clk);
    end

    // Streaming loads: one result per cycle, no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h8000_0000 + 64'(i * 16), 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
      #1;
      check($sformatf("stream%0d.req_ready", i), BUS_WD'(req_ready), BUS_WD'(1));
      check($sformatf("stream%0d.cs_valid", i), BUS_WD'(cs_valid), BUS_WD'(i > 0));
      check($sformatf("stream%0d.rd_cen", i), BUS_WD'(rd_cen), BUS_WD'(4'h0));
      check($sformatf("stream%0d.rd_addr", i), BUS_WD'(rd_addr), BUS_WD'(i));
      if (i > 0)
        check($sformatf("stream%0d.bus_addr", i), BUS_WD'(cs_bus[BUS_WD-1 -: 64]),
              BUS_WD'(64'h8000_0000 + 64'((i - 1) * 16)));
      @(negedge clk);
    end
    drive(1'b0, 64'h8000_0000, 8'h00, 1'b0, 1'b0, 6'h00, 1'b1);
    #1;
    check("stream_last.cs_valid", BUS_WD'(cs_valid), BUS_WD'(1));
    check("stream_last.bus_addr", BUS_WD'(cs_bus[BUS_WD-1 -: 64]), BUS_WD'(64'h8000_0070));
    check("stream_last.mask", BUS_WD'(cs_bus[3:0]), BUS_WD'(4'hf));
    @(negedge clk);

    // Reset while a request is held.
    drive(1'b1, 64'h8000_0040, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    #1;
    check("rst.accept_ready", BUS_WD'(req_ready), BUS_WD'(1));
    @(negedge clk);
    drive(1'b1, 64'h8000_0040, 8'h00, 1'b0, 1'b0, 6'h00, 1'b0);
    resetn = 1'b0;
    #1;
    check("rst.ready_in_reset", BUS_WD'(req_ready), BUS_WD'(0));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rst.cs_valid", BUS_WD'(cs_valid), BUS_WD'(0));
    check("rst.rd_cen", BUS_WD'(rd_cen), BUS_WD'(4'hf));
    check("rst.ready_after_edge", BUS_WD'(req_ready), BUS_WD'(0));
    check("rst.bus", cs_bus, '0);
    resetn = 1'b1;
    #1;
    check("rst.ready_released", BUS_WD'(req_ready), BUS_WD'(1));
    @(negedge clk);

    // Randomised run against the reference model. Starts in reset so model and DUT agree.
    m_held = 0; m_stale = 0; m_addr = '0; m_wdata = '0; m_wen = '0; m_mask = '0;
    for (int n = 0; n < 3000; n++) begin
      r   = (n == 0) ? 1'b0 : ($urandom_range(0, 99) >= 2);
      rv  = ($urandom_range(0, 99) < 70);
      a   = {$urandom, $urandom};
      a[9:4] = 6'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 99) < 5);
      we  = ($urandom_range(0, 99) < 30);
      wi  = 6'($urandom_range(0, 3));
      csr = ($urandom_range(0, 99) < 60);
      wn  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      resetn = r;
      drive(rv, a, wn, fl, we, wi, csr);

      ri      = a[9:4];
      hi      = m_addr[9:4];
      e_csv   = r && m_held && !m_stale;
      fire    = e_csv && csr;
      e_rdy   = r && !(rv && we && wi == ri) && !fl && (!m_held || fire);
      acc     = rv && e_rdy;
      rr      = r && m_held && !fire && !fl;
      e_cen   = (acc || rr) ? 4'h0 : 4'hf;
      e_raddr = (!acc && rr) ? hi : ri;

      #1;
      check("rnd.req_ready", BUS_WD'(req_ready), BUS_WD'(e_rdy));
      check("rnd.cs_valid", BUS_WD'(cs_valid), BUS_WD'(e_csv));
      check("rnd.rd_cen", BUS_WD'(rd_cen), BUS_WD'(e_cen));
      check("rnd.rd_addr", BUS_WD'(rd_addr), BUS_WD'(e_raddr));
      check("rnd.cs_bus", cs_bus, {m_addr, m_wdata, m_wen, m_mask});

      if (!r) begin
        m_held = 0; m_stale = 0; m_addr = '0; m_wdata = '0; m_wen = '0; m_mask = '0;
      end else if (fl) begin
        m_held = 0;
      end else if (acc) begin
        m_held  = 1;
        m_stale = we && wi == ri;
        m_addr  = a;
        m_wdata = {32'hd00d_f00d, a[31:0]};
        m_wen   = wn;
        m_mask  = 4'hf;
      end else if (fire) begin
        m_held = 0;
      end else if (m_held) begin
        // A write to the held set spoils this cycle's read; the next read is clean.
        m_stale = we && wi == hi;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
